// File: rtl/nc_ctx_predictor.sv
// nc_ctx_predictor: sequential CAVLC nC context engine.
// Holds total_coeff for the current MB, the right column of the previous MB
// (left context) and a per-column line buffer of bottom rows (up context).
// Answers one nC request per cycle with a registered result.
module nc_ctx_predictor #(
  parameter int MB_X_BITS   = 8,
  parameter int MB_Y_BITS   = 8,
  parameter int TC_BITS     = 5,
  parameter int CHROMA_BLKS = 4   // 4 = 4:2:0, 8 = 4:2:2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mb_start,
  input  logic [MB_X_BITS-1:0] mb_x,
  input  logic [MB_Y_BITS-1:0] mb_y,
  input  logic                 avail_left,
  input  logic                 avail_up,
  input  logic                 mb_done,
  input  logic                 wr_en,
  input  logic [1:0]           wr_comp,
  input  logic [3:0]           wr_blk_idx,
  input  logic [TC_BITS-1:0]   wr_tc,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_comp,
  input  logic [3:0]           req_blk_idx,
  output logic                 nc_valid,
  output logic [TC_BITS-1:0]   nc_out,
  output logic                 busy
);

  localparam int         LB_DEPTH = 1 << MB_X_BITS;
  localparam int         SUM_W    = TC_BITS + 1;
  localparam bit         IS_422   = (CHROMA_BLKS == 8);
  localparam logic [3:0] CB_LIMIT = 4'(CHROMA_BLKS);

  typedef logic [TC_BITS-1:0] tc_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_COMMIT} state_e;

  state_e state_q, state_d;

  logic [MB_X_BITS-1:0] mb_x_q, mb_x_d;
  logic                 left_ok_q, left_ok_d;
  logic                 up_ok_q, up_ok_d;

  // Chroma arrays are always sized for 4:2:2; in 4:2:0 the upper half stays 0.
  tc_t [15:0] cur_luma_q, cur_luma_d, luma_w;
  tc_t [7:0]  cur_cb_q, cur_cb_d, cb_w;
  tc_t [7:0]  cur_cr_q, cur_cr_d, cr_w;
  tc_t [3:0]  left_luma_q, left_luma_d;
  tc_t [3:0]  left_cb_q, left_cb_d;
  tc_t [3:0]  left_cr_q, left_cr_d;
  tc_t [3:0]  up_luma_q, up_luma_d;
  tc_t [1:0]  up_cb_q, up_cb_d;
  tc_t [1:0]  up_cr_q, up_cr_d;

  logic nc_valid_q, nc_valid_d;
  tc_t  nc_out_q, nc_out_d;

  // Line buffer entry: [3:0] luma bottom row, [5:4] Cb bottom row, [7:6] Cr.
  tc_t [7:0] lb_mem [LB_DEPTH];
  tc_t [7:0] lb_rdata_q;
  tc_t [7:0] lb_wdata;
  logic      lb_re, lb_we;

  logic             req_accept;
  logic [1:0]       rx, ry, ax, by;
  logic             req_in_range, a_av, b_av;
  tc_t              a_val, b_val, nc_calc;
  logic [SUM_W-1:0] nc_sum;

  // Current-MB block at (x,y); luma uses the zig-zag 4x4 index layout.
  function automatic tc_t pick_cur(input logic [1:0] comp, input logic [1:0] x,
                                   input logic [1:0] y, input tc_t [15:0] luma,
                                   input tc_t [7:0] cb, input tc_t [7:0] cr);
    tc_t v;
    case (comp)
      2'd0:    v = luma[{y[1], x[1], y[0], x[0]}];
      2'd1:    v = cb[{y, x[0]}];
      2'd2:    v = cr[{y, x[0]}];
      default: v = '0;
    endcase
    return v;
  endfunction

  // Left-MB right-column entry at row y.
  function automatic tc_t pick_left(input logic [1:0] comp, input logic [1:0] y,
                                    input tc_t [3:0] luma, input tc_t [3:0] cb,
                                    input tc_t [3:0] cr);
    tc_t v;
    case (comp)
      2'd0:    v = luma[y];
      2'd1:    v = cb[y];
      2'd2:    v = cr[y];
      default: v = '0;
    endcase
    return v;
  endfunction

  // Upper-MB bottom-row entry at column x.
  function automatic tc_t pick_up(input logic [1:0] comp, input logic [1:0] x,
                                  input tc_t [3:0] luma, input tc_t [1:0] cb,
                                  input tc_t [1:0] cr);
    tc_t v;
    case (comp)
      2'd0:    v = luma[x];
      2'd1:    v = cb[x[0]];
      2'd2:    v = cr[x[0]];
      default: v = '0;
    endcase
    return v;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (mb_start) state_d = S_LOAD;
      S_LOAD:   state_d = S_READY;
      S_READY:  if (mb_done) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    req_ready = (state_q == S_READY);
    busy      = (state_q != S_IDLE);
  end

  // Current-MB arrays with this cycle's honoured write applied (also feeds the bypass).
  always_comb begin
    luma_w = cur_luma_q;
    cb_w   = cur_cb_q;
    cr_w   = cur_cr_q;
    if (wr_en && state_q == S_READY) begin
      case (wr_comp)
        2'd0: luma_w[wr_blk_idx] = wr_tc;
        2'd1: if (wr_blk_idx < CB_LIMIT) cb_w[wr_blk_idx[2:0]] = wr_tc;
        2'd2: if (wr_blk_idx < CB_LIMIT) cr_w[wr_blk_idx[2:0]] = wr_tc;
        default: ;
      endcase
    end
  end

  // Neighbour selection and nC arithmetic for the incoming request.
  always_comb begin
    rx           = {req_blk_idx[2], req_blk_idx[0]};
    ry           = {req_blk_idx[3], req_blk_idx[1]};
    req_in_range = 1'b1;
    if (req_comp != 2'd0) begin
      rx           = {1'b0, req_blk_idx[0]};
      ry           = IS_422 ? req_blk_idx[2:1] : {1'b0, req_blk_idx[1]};
      req_in_range = (req_comp != 2'd3) && (req_blk_idx < CB_LIMIT);
    end
    ax = rx - 2'd1;
    by = ry - 2'd1;

    if (rx != 2'd0) begin
      a_av  = 1'b1;
      a_val = pick_cur(req_comp, ax, ry, luma_w, cb_w, cr_w);
    end else begin
      a_av  = left_ok_q;
      a_val = pick_left(req_comp, ry, left_luma_q, left_cb_q, left_cr_q);
    end

    if (ry != 2'd0) begin
      b_av  = 1'b1;
      b_val = pick_cur(req_comp, rx, by, luma_w, cb_w, cr_w);
    end else begin
      b_av  = up_ok_q;
      b_val = pick_up(req_comp, rx, up_luma_q, up_cb_q, up_cr_q);
    end

    nc_sum = SUM_W'(a_val) + SUM_W'(b_val) + SUM_W'(1);
    if (!req_in_range)    nc_calc = '0;
    else if (a_av && b_av) nc_calc = nc_sum[TC_BITS:1];
    else if (a_av)         nc_calc = a_val;
    else if (b_av)         nc_calc = b_val;
    else                   nc_calc = '0;
  end

  // Context register updates: MB start, up capture, commit, request result.
  always_comb begin
    mb_x_d      = mb_x_q;
    left_ok_d   = left_ok_q;
    up_ok_d     = up_ok_q;
    cur_luma_d  = luma_w;
    cur_cb_d    = cb_w;
    cur_cr_d    = cr_w;
    left_luma_d = left_luma_q;
    left_cb_d   = left_cb_q;
    left_cr_d   = left_cr_q;
    up_luma_d   = up_luma_q;
    up_cb_d     = up_cb_q;
    up_cr_d     = up_cr_q;
    lb_re       = 1'b0;
    lb_we       = 1'b0;
    lb_wdata    = {IS_422 ? {cur_cr_q[7], cur_cr_q[6]} : {cur_cr_q[3], cur_cr_q[2]},
                   IS_422 ? {cur_cb_q[7], cur_cb_q[6]} : {cur_cb_q[3], cur_cb_q[2]},
                   cur_luma_q[15], cur_luma_q[14], cur_luma_q[11], cur_luma_q[10]};

    req_accept = req_valid && (state_q == S_READY);
    nc_valid_d = req_accept;
    nc_out_d   = req_accept ? nc_calc : nc_out_q;

    case (state_q)
      S_IDLE: if (mb_start) begin
        mb_x_d     = mb_x;
        left_ok_d  = avail_left && (mb_x != '0);
        up_ok_d    = avail_up && (mb_y != '0);
        cur_luma_d = '0;
        cur_cb_d   = '0;
        cur_cr_d   = '0;
        lb_re      = 1'b1;
      end
      S_LOAD: begin
        up_luma_d = lb_rdata_q[3:0];
        up_cb_d   = lb_rdata_q[5:4];
        up_cr_d   = lb_rdata_q[7:6];
      end
      S_COMMIT: begin
        // A reset landing on the commit cycle discards the line-buffer write.
        lb_we       = !rst;
        left_luma_d = {cur_luma_q[15], cur_luma_q[13], cur_luma_q[7], cur_luma_q[5]};
        left_cb_d   = IS_422 ? {cur_cb_q[7], cur_cb_q[5], cur_cb_q[3], cur_cb_q[1]}
                             : {tc_t'(0), tc_t'(0), cur_cb_q[3], cur_cb_q[1]};
        left_cr_d   = IS_422 ? {cur_cr_q[7], cur_cr_q[5], cur_cr_q[3], cur_cr_q[1]}
                             : {tc_t'(0), tc_t'(0), cur_cr_q[3], cur_cr_q[1]};
      end
      default: ;
    endcase
  end

  // Context and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      mb_x_q      <= '0;
      left_ok_q   <= 1'b0;
      up_ok_q     <= 1'b0;
      cur_luma_q  <= '0;
      cur_cb_q    <= '0;
      cur_cr_q    <= '0;
      left_luma_q <= '0;
      left_cb_q   <= '0;
      left_cr_q   <= '0;
      up_luma_q   <= '0;
      up_cb_q     <= '0;
      up_cr_q     <= '0;
      nc_valid_q  <= 1'b0;
      nc_out_q    <= '0;
    end else begin
      mb_x_q      <= mb_x_d;
      left_ok_q   <= left_ok_d;
      up_ok_q     <= up_ok_d;
      cur_luma_q  <= cur_luma_d;
      cur_cb_q    <= cur_cb_d;
      cur_cr_q    <= cur_cr_d;
      left_luma_q <= left_luma_d;
      left_cb_q   <= left_cb_d;
      left_cr_q   <= left_cr_d;
      up_luma_q   <= up_luma_d;
      up_cb_q     <= up_cb_d;
      up_cr_q     <= up_cr_d;
      nc_valid_q  <= nc_valid_d;
      nc_out_q    <= nc_out_d;
    end
  end

  // Line buffer RAM with registered read port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM is deliberately not reset so it maps onto block memory; row 0 never reads it.
    if (lb_we) lb_mem[mb_x_q] <= lb_wdata;
    if (lb_re) lb_rdata_q <= lb_mem[mb_x];
  end

  assign nc_valid = nc_valid_q;
  assign nc_out   = nc_out_q;

endmodule

// File: tb/tb_nc_ctx_predictor.sv
// Directed bench for nc_ctx_predictor: a 4:2:0 and a 4:2:2 instance share
// one stimulus stream; expected nC values are worked out by hand below.
module tb_nc_ctx_predictor;

  logic       clk = 1'b0;
  logic       rst, mb_start, avail_left, avail_up, mb_done;
  logic [7:0] mb_x, mb_y;
  logic       wr_en, req_valid;
  logic [1:0] wr_comp, req_comp;
  logic [3:0] wr_blk_idx, req_blk_idx;
  logic [4:0] wr_tc;

  logic       req_ready_a, nc_valid_a, busy_a;
  logic [4:0] nc_out_a;
  logic       req_ready_b, nc_valid_b, busy_b;
  logic [4:0] nc_out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nc_ctx_predictor #(.MB_X_BITS(8), .MB_Y_BITS(8), .TC_BITS(5), .CHROMA_BLKS(4)) dut420 (
    .clk(clk), .rst(rst), .mb_start(mb_start), .mb_x(mb_x), .mb_y(mb_y),
    .avail_left(avail_left), .avail_up(avail_up), .mb_done(mb_done),
    .wr_en(wr_en), .wr_comp(wr_comp), .wr_blk_idx(wr_blk_idx), .wr_tc(wr_tc),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_comp(req_comp),
    .req_blk_idx(req_blk_idx), .nc_valid(nc_valid_a), .nc_out(nc_out_a), .busy(busy_a)
  );

  nc_ctx_predictor #(.MB_X_BITS(8), .MB_Y_BITS(8), .TC_BITS(5), .CHROMA_BLKS(8)) dut422 (
    .clk(clk), .rst(rst), .mb_start(mb_start), .mb_x(mb_x), .mb_y(mb_y),
    .avail_left(avail_left), .avail_up(avail_up), .mb_done(mb_done),
    .wr_en(wr_en), .wr_comp(wr_comp), .wr_blk_idx(wr_blk_idx), .wr_tc(wr_tc),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_comp(req_comp),
    .req_blk_idx(req_blk_idx), .nc_valid(nc_valid_b), .nc_out(nc_out_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_mb(input int x, input int y, input logic al, input logic au);
    mb_start = 1'b1; mb_x = 8'(x); mb_y = 8'(y); avail_left = al; avail_up = au;
    step();
    mb_start = 1'b0;
    step();
  endtask

  task automatic finish_mb();
    mb_done = 1'b1;
    step();
    mb_done = 1'b0;
    step();
  endtask

  task automatic write_blk(input logic [1:0] comp, input logic [3:0] idx, input logic [4:0] tc);
    wr_en = 1'b1; wr_comp = comp; wr_blk_idx = idx; wr_tc = tc;
    step();
    wr_en = 1'b0;
  endtask

  task automatic request(input string tag, input logic [1:0] comp, input logic [3:0] idx,
                         input int exp420, input int exp422);
    req_valid = 1'b1; req_comp = comp; req_blk_idx = idx;
    check({tag, "_rdy"}, 32'(req_ready_a), 1);
    step();
    req_valid = 1'b0;
    check({tag, "_vld"}, 32'(nc_valid_a), 1);
    check(tag, 32'(nc_out_a), 32'(exp420));
    check({tag, "_422"}, 32'(nc_out_b), 32'(exp422));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mb_start = 1'b0; mb_x = '0; mb_y = '0; avail_left = 1'b0; avail_up = 1'b0;
    mb_done = 1'b0; wr_en = 1'b0; wr_comp = '0; wr_blk_idx = '0; wr_tc = '0;
    req_valid = 1'b0; req_comp = '0; req_blk_idx = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy_a), 0);
    check("rst_rdy", 32'(req_ready_a), 0);
    check("rst_vld", 32'(nc_valid_a), 0);
    check("rst_nc", 32'(nc_out_a), 0);

    // MB (0,0): both neighbours masked off by position.
    mb_start = 1'b1; mb_x = 8'd0; mb_y = 8'd0; avail_left = 1'b1; avail_up = 1'b1;
    step();
    mb_start = 1'b0;
    check("load_busy", 32'(busy_a), 1);
    check("load_rdy", 32'(req_ready_a), 0);
    step();
    check("ready_rdy", 32'(req_ready_a), 1);
    request("b_luma0", 2'd0, 4'd0, 0, 0);
    request("b_cb3", 2'd1, 4'd3, 0, 0);
    write_blk(2'd0, 4'd1, 5'd3);
    write_blk(2'd0, 4'd2, 5'd6);
    // idx3: nA = blk2 = 6, nB = blk1 = 3 -> (6+3+1)>>1 = 5
    request("b_avg3", 2'd0, 4'd3, 5, 5);
    step();
    check("b_pulse", 32'(nc_valid_a), 0);
    check("b_hold", 32'(nc_out_a), 5);
    // Same-cycle write of blk0=8 and request of blk1: nA bypassed = 8, no up.
    wr_en = 1'b1; wr_comp = 2'd0; wr_blk_idx = 4'd0; wr_tc = 5'd8;
    request("b_bypass", 2'd0, 4'd1, 8, 8);
    wr_en = 1'b0;
    // comp=3 write must not land anywhere; Cr blk1 sees Cr blk0 = 0.
    write_blk(2'd3, 4'd0, 5'd15);
    request("b_comp3_wr", 2'd2, 4'd1, 0, 0);
    request("b_comp3_req", 2'd3, 4'd0, 0, 0);
    write_blk(2'd0, 4'd5, 5'd4);
    // mb_done with a request (idx3 -> 5) and a write of blk7=2 in the same cycle.
    mb_done = 1'b1; req_valid = 1'b1; req_comp = 2'd0; req_blk_idx = 4'd3;
    wr_en = 1'b1; wr_comp = 2'd0; wr_blk_idx = 4'd7; wr_tc = 5'd2;
    step();
    mb_done = 1'b0; req_valid = 1'b0; wr_en = 1'b0;
    check("done_vld", 32'(nc_valid_a), 1);
    check("done_nc", 32'(nc_out_a), 5);
    check("commit_rdy", 32'(req_ready_a), 0);
    check("commit_busy", 32'(busy_a), 1);
    step();
    check("idle_busy", 32'(busy_a), 0);

    // MB (1,0) with left: left column = {5:4, 7:2, 13:0, 15:0}.
    mb_start = 1'b1; mb_x = 8'd1; mb_y = 8'd0; avail_left = 1'b1; avail_up = 1'b1;
    step();
    mb_start = 1'b0;
    req_valid = 1'b1; req_comp = 2'd0; req_blk_idx = 4'd0;
    check("load_no_accept", 32'(req_ready_a), 0);
    step();
    req_valid = 1'b0;
    check("load_no_vld", 32'(nc_valid_a), 0);
    request("c_left0", 2'd0, 4'd0, 4, 4);
    // idx2: nA = left row1 = 2, nB = blk0 = 0 -> (2+0+1)>>1 = 1
    request("c_left2", 2'd0, 4'd2, 1, 1);
    write_blk(2'd0, 4'd5, 5'd9);
    finish_mb();

    // MB (1,0) again without left: left row0 holds 9 but is unavailable.
    start_mb(1, 0, 1'b0, 1'b1);
    request("d_noleft", 2'd0, 4'd0, 0, 0);
    write_blk(2'd0, 4'd5, 5'd9);
    finish_mb();

    // MB (2,0): seed the line buffer and exercise 4:2:2 chroma geometry.
    start_mb(2, 0, 1'b0, 1'b1);
    write_blk(2'd0, 4'd10, 5'd7);
    write_blk(2'd0, 4'd11, 5'd9);
    write_blk(2'd0, 4'd13, 5'd12);
    write_blk(2'd1, 4'd2, 5'd5);
    write_blk(2'd1, 4'd6, 5'd11);
    write_blk(2'd2, 4'd4, 5'd6);
    write_blk(2'd2, 4'd7, 5'd2);
    // 4:2:2 Cr6 (0,3): nB = Cr4 = 6, no left -> 6; 4:2:0 index out of range -> 0
    request("e_cr6", 2'd2, 4'd6, 0, 6);
    // 4:2:2 Cr5 (1,2): nA = Cr4 = 6, nB = Cr3 = 0 -> 3; 4:2:0 -> 0
    request("e_cr5", 2'd2, 4'd5, 0, 3);
    finish_mb();

    // MB (0,1): left row2 holds 12, but x=0 forces left unavailable; nB = blk2 = 0.
    start_mb(0, 1, 1'b1, 1'b0);
    request("f_x0_mask", 2'd0, 4'd8, 0, 0);
    finish_mb();

    // MB (2,1): up from line buffer: luma {7,9,0,0}; Cb col0 5 (4:2:0) / 11 (4:2:2).
    start_mb(2, 1, 1'b0, 1'b1);
    // blk0 = 9 so idx1 averages 9 with up value 9 -> 9
    write_blk(2'd0, 4'd0, 5'd9);
    request("g_up0", 2'd0, 4'd0, 7, 7);
    request("g_up1", 2'd0, 4'd1, 9, 9);
    request("g_cb0", 2'd1, 4'd0, 5, 11);
    // Cr1: nA = Cr0 = 0; nB = up Cr col1: 0 (4:2:0), Cr7 = 2 (4:2:2) -> 1
    request("g_cr1", 2'd2, 4'd1, 0, 1);
    write_blk(2'd0, 4'd10, 5'd13);
    mb_done = 1'b1;
    step();
    mb_done = 1'b0;
    check("g_commit_rdy", 32'(req_ready_a), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_busy", 32'(busy_a), 0);
    check("rst2_rdy", 32'(req_ready_a), 0);
    check("rst2_vld", 32'(nc_valid_b), 0);
    check("rst2_nc_422", 32'(nc_out_b), 0);

    // MB (2,2): the interrupted commit must not have replaced blk10 = 7.
    start_mb(2, 2, 1'b0, 1'b1);
    request("h_lb_kept", 2'd0, 4'd0, 7, 7);
    // idx1: nA = blk0 = 0, nB = up col1 = 9 -> 5
    request("h_up1", 2'd0, 4'd1, 5, 5);
    finish_mb();
    check("h_idle_busy", 32'(busy_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nc_ctx_predictor.md
# nc_ctx_predictor

Sequential CAVLC nC context engine for the entropy-decode stage. It owns the total_coeff context for the current macroblock, the left macroblock and a per-column top line buffer. On request it returns the registered nC for any luma, Cb or Cr 4x4 block. The block is parametrised in picture width, coefficient-count width and chroma format (4:2:0 or 4:2:2). It replaces the per-MB combinational neighbour muxing: the caller no longer marshals neighbour vectors and only streams block writes and requests.

## Interface
- MB_X_BITS, 8: width of mb_x; the line buffer holds 2**MB_X_BITS entries.
- MB_Y_BITS, 8: width of mb_y.
- TC_BITS, 5: width of one total_coeff entry and of nc_out (0..16).
- CHROMA_BLKS, 4: 4x4 blocks per chroma component per MB. 4 means 4:2:0 and 8 means 4:2:2; other values are illegal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mb_start  in  1  pulse: begin macroblock; sampled only in IDLE.
- mb_x  in  MB_X_BITS  MB column, sampled with mb_start.
- mb_y  in  MB_Y_BITS  MB row, sampled with mb_start.
- avail_left  in  1  left MB is in the same slice, sampled with mb_start.
- avail_up  in  1  upper MB is in the same slice, sampled with mb_start.
- mb_done  in  1  pulse: current MB finished; sampled only in READY.
- wr_en  in  1  store total_coeff for one block; honoured only in READY.
- wr_comp  in  2  0 luma, 1 Cb, 2 Cr (3 ignored).
- wr_blk_idx  in  4  luma: spec 4x4 index 0..15; chroma: 0..CHROMA_BLKS-1.
- wr_tc  in  TC_BITS  total_coeff value. The caller writes 16 for I_PCM blocks.
- req_valid  in  1  nC request.
- req_ready  out  1  high only in READY.
- req_comp  in  2  component, same encoding as wr_comp.
- req_blk_idx  in  4  block index, same encoding as wr_blk_idx.
- nc_valid  out  1  one-cycle pulse, one cycle after request accept.
- nc_out  out  TC_BITS  nC; holds its value until the next nc_valid.
- busy  out  1  state is not IDLE.

## Operation
- States are IDLE, LOAD, READY and COMMIT.
- IDLE -> LOAD on mb_start.
  - Latch mb_x, mb_y, the left flag (avail_left && mb_x!=0) and the up flag (avail_up && mb_y!=0).
  - Issue a line-buffer read at mb_x.
  - Clear all current-MB entries to 0.
- LOAD -> READY after one cycle. The RAM data (4 luma + 2 Cb + 2 Cr bottom-row entries) is captured into up registers.
- READY -> COMMIT on mb_done.
- COMMIT -> IDLE after one cycle. During COMMIT:
  - The bottom row of the current MB is written to the line buffer at the latched mb_x: luma 10,11,14,15; chroma bottom row per format.
  - The right column is copied into the left registers: luma 5,7,13,15; chroma right column, with 2 entries per component for 4:2:0 and 4 for 4:2:2.
- Block geometry:
  - Luma x/y come from the standard zig-zag 4x4 index: x={idx[2],idx[0]}, y={idx[3],idx[1]}.
  - Chroma x=idx[0]; y=idx[1] for 4:2:0 and y=idx[2:1] for 4:2:2.
- Neighbour rules:
  - nA is the current-MB block to the left when x>0. Otherwise it is the left register at row y, available only if the left flag is set.
  - nB is the current-MB block above when y>0. Otherwise it is the up register at column x, available only if the up flag is set.
- nC arithmetic is done at TC_BITS+1 bits with no overflow:
  - both available: (nA+nB+1)>>1;
  - one available: that value;
  - none: 0.
- Write bypass: a write and a request in the same cycle use the newly written value if the request's neighbour is the written block.
- Skipped MBs (mb_start then mb_done with no writes) commit all zeros.
- Out-of-range chroma index (>= CHROMA_BLKS) or comp=3: writes are ignored; requests return nC=0 with nc_valid still pulsed.
- Requests outside READY are not accepted (req_ready=0).
- mb_start outside IDLE and mb_done outside READY are ignored.

## Timing
- Reset values: state IDLE; req_ready=0, nc_valid=0, nc_out=0, busy=0; current, left and up registers 0.
  - The line buffer is not cleared; the caller restarts at mb (0,0) after reset, so no row 0 read is ever used.
- mb_start at cycle T: busy=1 at T+1; req_ready=1 at T+2.
- Request accepted at cycle T: nc_valid=1 and nc_out are valid at T+1. Back-to-back accepts give one result per cycle.
- mb_done at T (READY): req_ready=0 at T+1 (COMMIT), IDLE at T+2. The earliest next mb_start is at T+2.
- A request and mb_done in the same cycle: the request is served (nc_valid at T+1), then COMMIT.
- A write in the mb_done cycle is included in the commit.
- rst in any state returns to IDLE next cycle and drops in-flight nc_valid. A COMMIT write interrupted by rst is discarded.
- Throughput is 3 overhead cycles per MB plus one cycle per request.

## Test plan
- Reset/corner: after rst, MB (0,0) with no writes; luma req idx 0 -> nc_out=0. Cb req idx 3 -> 0.
- Intra-MB average: MB (0,0), write luma 1=3 and 2=6; request idx 3 -> nc_out=5 at accept+1, nc_valid high exactly one cycle.
- Cross-MB left/up: MB (0,0) writes luma 5=4 and commits; MB (1,0) with avail_left=1, request idx 0 -> 4. Then with avail_left=0 on MB (1,0) -> 0.
- Line buffer: row 0 MB x=2 writes luma 10=7, 11=9; at row 1 MB x=2 avail_up=1, avail_left=0: req idx 0 -> 7, idx 1 -> 9.
- 4:2:2 (CHROMA_BLKS=8): Cr write idx 4=6 and idx 7=2; request idx 6 -> nB=idx4=6, nA=left col unavailable -> 6. Request idx 5 -> nA=4's value 6, nB=3's value 0 -> 3.
- Bypass/reset: write luma 0=8 and request idx 1 in the same cycle -> 8 (left only, MB x=0). Assert rst during COMMIT -> IDLE, busy=0, req_ready=0, next row shows no write at that mb_x.
